// File: rtl/nibble_add_seq.sv
// Sequences one external 4-bit CLA slice to perform a WIDTH-bit add/subtract,
// one nibble per clock, LSB first, with request/response handshakes.
module nibble_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned StepW = $clog2(NIB);
  localparam int unsigned IdxW  = StepW + 2;
  localparam logic [StepW-1:0] LastStep = StepW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [StepW-1:0] step_q, step_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             req_ready_q;
  logic [IdxW-1:0]  bit_idx;
  logic             accept;
  logic             last_step;

  assign bit_idx   = {step_q, 2'b00};
  assign accept    = (state_q == StIdle) && req_valid && req_ready_q;
  assign last_step = (step_q == LastStep);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the slice is driven only while stepping
  always_comb begin
    req_ready = req_ready_q;
    rsp_valid = (state_q == StDone);
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
    cla_a     = 4'h0;
    cla_b     = 4'h0;
    cla_cin   = 1'b0;
    if (state_q == StRun) begin
      cla_a   = a_q[bit_idx +: 4];
      cla_b   = b_q[bit_idx +: 4];
      cla_cin = carry_q;
    end
  end

  // Datapath next-state
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    step_d      = step_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    if (accept) begin
      a_d     = op_a;
      b_d     = op_b ^ {WIDTH{op_sub}};
      carry_d = op_sub;
      step_d  = '0;
    end else if (state_q == StRun) begin
      result_d[bit_idx +: 4] = cla_sum;
      carry_d                = cla_cout;
      if (last_step) begin
        step_d      = '0;
        carry_out_d = cla_cout;
        overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
      end else begin
        step_d = step_q + StepW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      step_q      <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      step_q      <= step_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      req_ready_q <= (state_d == StIdle);
    end
  end

endmodule
